// File: rtl/check_node_ms.sv
`default_nettype none
// ============================================================================
// check_node_ms : serial min-sum LDPC check node (min1/min2/idx/parity scan)
// Rev 1.0
// ============================================================================
module check_node_ms #(
    parameter int weight = 6,
    parameter int length = 15,
    parameter int OFFSET = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [weight*length-1:0] variable_value_input,
    input  logic [weight-1:0]        variable_enable_input,
    output logic [weight*length-1:0] check_value_output,
    output logic [weight-1:0]        check_enable_output,
    output logic                     syndrome,
    output logic                     busy
);

    localparam int            MW      = length - 1;
    localparam int            CW      = (weight > 1) ? $clog2(weight) : 1;
    localparam logic [MW-1:0] MAG_MAX = {MW{1'b1}};
    localparam logic [MW-1:0] OFF     = MW'(OFFSET);
    localparam logic [CW-1:0] LAST    = CW'(weight - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        OUTPUT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t            state;
    logic [length-1:0] msg [weight];
    logic [MW-1:0]     min1;
    logic [MW-1:0]     min2;
    logic [CW-1:0]     idx;
    logic [CW-1:0]     cnt;
    logic              parity;

    logic [length-1:0]        cur;
    logic [length-1:0]        cur_abs;
    logic [MW-1:0]            cur_mag;
    logic [weight*length-1:0] out_next;

    // The most negative code has no positive twin; it saturates to MAG_MAX.
    always_comb begin
        cur     = msg[cnt];
        cur_abs = cur[length-1] ? -cur : cur;
        cur_mag = cur_abs[length-1] ? MAG_MAX : cur_abs[MW-1:0];
    end

    generate
        for (genvar i = 0; i < weight; i++) begin : g_out
            logic [MW-1:0]     m;
            logic [MW-1:0]     m_off;
            logic [length-1:0] pos;
            logic [length-1:0] val;
            always_comb begin
                m     = (idx == CW'(i)) ? min2 : min1;
                m_off = (m > OFF) ? (m - OFF) : '0;
                pos   = {1'b0, m_off};
                val   = (parity ^ msg[i][length-1]) ? -pos : pos;
            end
            assign out_next[i*length +: length] = val;
        end
    endgenerate

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= IDLE;
            min1                <= '0;
            min2                <= '0;
            idx                 <= '0;
            cnt                 <= '0;
            parity              <= 1'b0;
            check_value_output  <= '0;
            check_enable_output <= '0;
            syndrome            <= 1'b0;
            for (int i = 0; i < weight; i++) begin
                msg[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (&variable_enable_input) begin
                        for (int i = 0; i < weight; i++) begin
                            msg[i] <= variable_value_input[i*length +: length];
                        end
                        min1   <= MAG_MAX;
                        min2   <= MAG_MAX;
                        idx    <= '0;
                        cnt    <= '0;
                        parity <= 1'b0;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    // Strict compares: the earliest of equal magnitudes keeps min1.
                    if (cur_mag < min1) begin
                        min2 <= min1;
                        min1 <= cur_mag;
                        idx  <= cnt;
                    end else if (cur_mag < min2) begin
                        min2 <= cur_mag;
                    end
                    parity <= parity ^ cur[length-1];
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    check_value_output  <= out_next;
                    syndrome            <= parity;
                    check_enable_output <= '1;
                    state               <= HOLD;
                end
                HOLD: begin
                    if (variable_enable_input == '0) begin
                        check_enable_output <= '0;
                        state               <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/check_node_ms.md
Name: check_node_ms

Overview:
- Min-sum check node for the LDPC MS decoder; sits directly downstream of the variable nodes and upstream of them in the iteration loop.
- Receives one variable-to-check LLR message per connected edge and scans them serially to find min1, min2, the index of min1 and the sign parity.
- Returns one extrinsic check-to-variable message per edge, plus a per-check syndrome bit for the decision logic.

Parameters:
- weight, 6, number of variable nodes connected to this check node (>=1).
- length, 15, LLR width in bits, two's complement.
- OFFSET, 0, offset-min-sum correction subtracted from output magnitudes; 0 gives plain min-sum.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-low.
- variable_value_input  input  weight*length  edge messages; edge i occupies bits [length*(i+1)-1 : length*i].
- variable_enable_input  input  weight  per-edge message-valid bits from the variable nodes.
- check_value_output  output  weight*length  check-to-variable messages, same packing as the input.
- check_enable_output  output  weight  all bits driven identically; high means the outputs are valid.
- syndrome  output  1  XOR of the hard-decision signs of all edges; 1 means the parity check is unsatisfied.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst low, async): every output is 0, all internal registers are cleared, and the state is IDLE. Reset mid-operation aborts immediately with no partial output.
- States: IDLE, SCAN, OUTPUT, HOLD.
- IDLE: when variable_enable_input is all ones at a clock edge (edge T), the block:
  - captures all weight messages into internal registers;
  - sets min1 = min2 = 2^(length-1)-1, idx = 0, parity = 0, cnt = 0;
  - moves to SCAN.
- IDLE with any enable bit low: stay in IDLE.
- SCAN: one edge per cycle, k = cnt, over edges T+1 .. T+weight.
  - sign_k = MSB of message k; mag_k = |message k|.
  - -2^(length-1) saturates to a magnitude of 2^(length-1)-1.
  - If mag_k < min1: min2 <= min1, min1 <= mag_k, idx <= k.
  - Else if mag_k < min2: min2 <= mag_k.
  - Ties use strict compare, so the earliest index keeps min1 and an equal value goes to min2.
  - parity <= parity XOR sign_k; cnt increments.
  - After edge k = weight-1 is processed, move to OUTPUT.
- Changes on the inputs during SCAN are ignored; only the captured copies are used.
- OUTPUT (one cycle; outputs registered at edge T+weight+1):
  - m = (i == idx) ? min2 : min1.
  - m' = m - OFFSET, clamped at 0.
  - Output sign s_i = parity XOR sign_i.
  - check_value[i] = s_i ? -m' : +m'; a magnitude of 0 is always output as +0.
  - syndrome <= parity; check_enable_output <= all ones; move to HOLD.
  - Latency from the capture edge to check_enable high is weight+1 cycles.
- HOLD:
  - check_value_output, syndrome and check_enable_output stay stable.
  - When variable_enable_input is all zeros (the variable nodes have consumed the outputs and dropped their enables), drive check_enable_output to 0 and return to IDLE. check_value_output and syndrome keep their last values.
  - Requiring all-zero before leaving HOLD prevents stale enables from retriggering a capture.
- weight = 1: min2 stays at its initial value, so the single output is ±(2^(length-1)-1 - OFFSET) with sign = sign_0 XOR sign_0 = 0, i.e. a positive value.
- Width: magnitudes use length-1 bits; negating m' never overflows.

Test Plan (weight=4, length=8, OFFSET=0 unless stated):
- Inputs 5,-3,7,-10, all enables high at edge T -> at edge T+5: outputs +3,-5,+3,-3, syndrome=0, check_enable=4'b1111, busy=1.
- Tie case: inputs 4,4,-4,9 -> outputs -4,-4,+4,-4, syndrome=1.
- Saturation: inputs -128,100,50,60 -> outputs +50,-50,-60,-50, syndrome=1.
- OFFSET=2 with inputs 5,-3,7,-10 -> outputs +1,-3,+1,-1. A second run with inputs 1,-1,2,2 -> the clamped magnitude 0 is output as +0.
- Handshake: enables held high through HOLD -> outputs stable with no recapture. Enables set to 0000 -> check_enable drops next edge, state returns to IDLE, busy=0. Partial enables 1011 in IDLE -> no capture.
- Reset asserted mid-SCAN -> all outputs 0 immediately, state IDLE. After release, a fresh all-ones capture produces the correct result.
